// File: rtl/seq_det_ctrl.sv
// seq_det_ctrl: programmable serial sequence detector controller.
//
// A pattern configuration (bits, length, overlap mode, match threshold) is
// accepted through a ready/valid handshake while idle. A run scans the
// qualified serial stream, pulses on each match, counts matches and raises a
// sticky interrupt when the threshold is reached.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-low reset
//   cfg_valid    configuration write request
//   cfg_ready    high only while idle
//   cfg_pattern  pattern bits, bit [len-1] oldest, bit 0 newest
//   cfg_len      pattern length, legal 1..PAT_W
//   cfg_overlap  1 = overlapping detection, 0 = non-overlapping
//   cfg_thresh   match count that halts the run, 0 = never halt
//   cfg_err      one-cycle pulse when an illegal length is rejected
//   start        begin a run (idle only)
//   stop         abort a run (run or halt)
//   signal       serial data bit
//   sig_valid    qualifies signal
//   out          one-cycle match pulse, one cycle after the sampling edge
//   match_cnt    matches in the current run, saturating
//   irq          sticky threshold-reached flag
//   busy         high while running or halted
//
// state    | meaning
// st_idle  | accepting configuration, waiting for start
// st_run   | sampling the stream and counting matches
// st_halt  | threshold reached, stream ignored until stop

module seq_det_ctrl #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8,
  parameter int LEN_W = $clog2(PAT_W + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cfg_overlap,
  input  logic [CNT_W-1:0] cfg_thresh,
  output logic             cfg_err,
  input  logic             start,
  input  logic             stop,
  input  logic             signal,
  input  logic             sig_valid,
  output logic             out,
  output logic [CNT_W-1:0] match_cnt,
  output logic             irq,
  output logic             busy
);

  typedef enum logic [1:0] {
    st_idle = 2'd0,
    st_run  = 2'd1,
    st_halt = 2'd2
  } state_t;

  state_t           state;
  logic [PAT_W-1:0] pat;
  logic [LEN_W-1:0] len;
  logic             ovl;
  logic [CNT_W-1:0] thresh;
  logic [PAT_W-1:0] hist;
  logic [LEN_W-1:0] fill;

  logic [PAT_W-1:0] hist_n;
  logic [LEN_W-1:0] fill_n;
  logic [PAT_W-1:0] len_mask;
  logic             hit;
  logic             cfg_len_ok;
  logic [CNT_W-1:0] cnt_inc;

  assign cfg_ready = (state == st_idle);
  assign busy      = (state != st_idle);

  always_comb begin
    hist_n   = {hist[PAT_W-2:0], signal};
    fill_n   = (fill == LEN_W'(PAT_W)) ? fill : fill + LEN_W'(1);
    len_mask = '0;
    for (int i = 0; i < PAT_W; i++) begin
      len_mask[i] = (LEN_W'(i) < len);
    end
    // Only the newest len bits take part in the compare.
    hit        = (fill_n >= len) && ((hist_n & len_mask) == (pat & len_mask));
    cfg_len_ok = (cfg_len != '0) && (cfg_len <= LEN_W'(PAT_W));
    cnt_inc    = (match_cnt == {CNT_W{1'b1}}) ? match_cnt : match_cnt + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= st_idle;
      pat       <= '0;
      len       <= LEN_W'(PAT_W);
      ovl       <= 1'b1;
      thresh    <= '0;
      hist      <= '0;
      fill      <= '0;
      out       <= 1'b0;
      match_cnt <= '0;
      irq       <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      out     <= 1'b0;
      cfg_err <= 1'b0;

      // A write landing together with start is already in place for the run.
      if (state == st_idle && cfg_valid) begin
        if (cfg_len_ok) begin
          pat    <= cfg_pattern;
          len    <= cfg_len;
          ovl    <= cfg_overlap;
          thresh <= cfg_thresh;
        end else begin
          cfg_err <= 1'b1;
        end
      end

      case (state)
        st_idle: begin
          if (start && !stop) begin
            state     <= st_run;
            match_cnt <= '0;
            irq       <= 1'b0;
            hist      <= '0;
            fill      <= '0;
          end
        end
        st_run: begin
          if (stop) begin
            state <= st_idle;
            irq   <= 1'b0;
          end else if (sig_valid) begin
            hist <= hist_n;
            if (hit) begin
              out       <= 1'b1;
              match_cnt <= cnt_inc;
              fill      <= ovl ? fill_n : '0;
              if (thresh != '0 && cnt_inc == thresh) begin
                state <= st_halt;
                irq   <= 1'b1;
              end
            end else begin
              fill <= fill_n;
            end
          end
        end
        st_halt: begin
          if (stop) begin
            state <= st_idle;
            irq   <= 1'b0;
          end
        end
        default: begin
          state <= st_idle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_det_ctrl.sv
module tb_seq_det_ctrl;
  localparam int PAT_W = 4;
  localparam int CNT_W = 8;
  localparam int LEN_W = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             cfg_valid = 1'b0;
  logic             cfg_ready;
  logic [PAT_W-1:0] cfg_pattern = '0;
  logic [LEN_W-1:0] cfg_len = '0;
  logic             cfg_overlap = 1'b0;
  logic [CNT_W-1:0] cfg_thresh = '0;
  logic             cfg_err;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic             signal = 1'b0;
  logic             sig_valid = 1'b0;
  logic             out;
  logic [CNT_W-1:0] match_cnt;
  logic             irq;
  logic             busy;

  seq_det_ctrl #(.PAT_W(PAT_W), .CNT_W(CNT_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cfg_overlap(cfg_overlap), .cfg_thresh(cfg_thresh), .cfg_err(cfg_err),
    .start(start), .stop(stop), .signal(signal), .sig_valid(sig_valid),
    .out(out), .match_cnt(match_cnt), .irq(irq), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phase 0 idle, 1 running, 2 halted. The stream seen since
  // the run began (or since the last non-overlapping match) is kept as a queue.
  int               m_phase;
  int               m_q[$];
  logic [PAT_W-1:0] m_pat;
  int               m_len;
  bit               m_ovl;
  int               m_thr;
  int               m_cnt;
  bit               m_irq;
  bit               m_out;
  bit               m_err;

  function automatic bit tail_matches();
    for (int k = 0; k < m_len; k++) begin
      if (m_q[m_q.size() - 1 - k] != int'(m_pat[k])) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_q.delete(); m_pat = '0; m_len = PAT_W; m_ovl = 1'b1;
    m_thr = 0; m_cnt = 0; m_irq = 1'b0; m_out = 1'b0; m_err = 1'b0;
  endtask

  task automatic model_step();
    m_out = 1'b0;
    m_err = 1'b0;
    if (m_phase == 0 && cfg_valid) begin
      if (cfg_len >= 1 && int'(cfg_len) <= PAT_W) begin
        m_pat = cfg_pattern; m_len = int'(cfg_len);
        m_ovl = cfg_overlap; m_thr = int'(cfg_thresh);
      end else begin
        m_err = 1'b1;
      end
    end
    if (m_phase == 0) begin
      if (start && !stop) begin
        m_phase = 1; m_cnt = 0; m_irq = 1'b0; m_q.delete();
      end
    end else if (stop) begin
      m_phase = 0; m_irq = 1'b0;
    end else if (m_phase == 1 && sig_valid) begin
      m_q.push_back(int'(signal));
      if (m_q.size() > PAT_W) void'(m_q.pop_front());
      if (m_q.size() >= m_len && tail_matches()) begin
        m_out = 1'b1;
        if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
        if (!m_ovl) m_q.delete();
        if (m_thr != 0 && m_cnt == m_thr) begin
          m_phase = 2; m_irq = 1'b1;
        end
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) model_reset();
      else model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      chk("out", out, m_out);
      chk("match_cnt", match_cnt, m_cnt);
      chk("irq", irq, m_irq);
      chk("busy", busy, m_phase != 0);
      chk("cfg_ready", cfg_ready, m_phase == 0);
      chk("cfg_err", cfg_err, m_err);
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_cfg(input logic [3:0] p, input int l, input bit o, input int t, input bit st);
    cfg_valid = 1'b1; cfg_pattern = p; cfg_len = LEN_W'(l);
    cfg_overlap = o; cfg_thresh = CNT_W'(t); start = st;
    tick();
    cfg_valid = 1'b0; start = 1'b0;
  endtask

  task automatic send(input bit b, input bit v, input bit exp_out, input string nm);
    signal = b; sig_valid = v;
    tick();
    chk(nm, out, exp_out);
    sig_valid = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1; tick(); stop = 1'b0;
  endtask

  task automatic send_stream(input logic [7:0] s, input logic [7:0] e, input string nm);
    for (int i = 0; i < 8; i++) send(s[7-i], 1'b1, e[7-i], nm);
  endtask

  initial begin
    logic [7:0] s;
    logic [7:0] e;
    repeat (2) tick();
    chk("reset_out", out, 0);
    chk("reset_cnt", match_cnt, 0);
    chk("reset_irq", irq, 0);
    chk("reset_ready", cfg_ready, 1);
    #2 rst = 1'b1;
    tick();

    // overlapping 1011 on 11011011: matches after bits 5 and 8
    do_cfg(4'b1011, 4, 1'b1, 0, 1'b1);
    s = 8'b11011011; e = 8'b00001001;
    send_stream(s, e, "t1_out");
    chk("t1_cnt", match_cnt, 2);
    chk("t1_irq", irq, 0);
    chk("t1_busy", busy, 1);
    do_stop();
    chk("t1_stop_busy", busy, 0);
    chk("t1_stop_cnt", match_cnt, 2);

    // non-overlapping: only the first match
    do_cfg(4'b1011, 4, 1'b0, 0, 1'b1);
    e = 8'b00001000;
    send_stream(s, e, "t2_out");
    chk("t2_cnt", match_cnt, 1);
    do_stop();

    // threshold 2: halt at bit 7, bit 8 ignored
    do_cfg(4'b1011, 4, 1'b1, 2, 1'b1);
    s = 8'b10110111; e = 8'b00010010;
    for (int i = 0; i < 7; i++) send(s[7-i], 1'b1, e[7-i], "t3_out");
    chk("t3_irq", irq, 1);
    chk("t3_busy", busy, 1);
    send(1'b1, 1'b1, 1'b0, "t3_halt_out");
    chk("t3_halt_cnt", match_cnt, 2);
    do_stop();
    chk("t3_ready", cfg_ready, 1);
    chk("t3_irq_clr", irq, 0);
    chk("t3_cnt_hold", match_cnt, 2);

    // illegal length rejected, config (1011/4/ovl/thr2) retained
    do_cfg(4'b0000, 0, 1'b0, 0, 1'b0);
    chk("t4_err", cfg_err, 1);
    tick();
    chk("t4_err_clr", cfg_err, 0);
    start = 1'b1; tick(); start = 1'b0;
    s = 8'b00001011; e = 8'b00000001;
    for (int i = 4; i < 8; i++) send(s[7-i], 1'b1, e[7-i], "t4_out");
    chk("t4_cnt", match_cnt, 1);
    do_cfg(4'b0000, 0, 1'b0, 0, 1'b0);
    chk("t4_busy_err", cfg_err, 0);
    do_stop();
    start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
    chk("t4_startstop", busy, 0);

    // gaps inside a 1011 occurrence
    do_cfg(4'b1011, 4, 1'b1, 0, 1'b1);
    send(1'b1, 1'b1, 1'b0, "t5_out");
    send(1'b0, 1'b0, 1'b0, "t5_out");
    send(1'b0, 1'b1, 1'b0, "t5_out");
    send(1'b1, 1'b0, 1'b0, "t5_out");
    send(1'b1, 1'b1, 1'b0, "t5_out");
    send(1'b0, 1'b0, 1'b0, "t5_out");
    send(1'b1, 1'b1, 1'b1, "t5_gap_match");
    do_stop();
    do_cfg(4'b0011, 2, 1'b1, 0, 1'b1);
    send(1'b1, 1'b1, 1'b0, "t5b_out");
    send(1'b1, 1'b1, 1'b1, "t5b_out");
    send(1'b1, 1'b1, 1'b1, "t5b_out");
    chk("t5b_cnt", match_cnt, 2);
    do_stop();

    // saturation with a one-bit pattern
    do_cfg(4'b0001, 1, 1'b1, 0, 1'b1);
    signal = 1'b1; sig_valid = 1'b1;
    repeat (260) tick();
    sig_valid = 1'b0;
    chk("sat_cnt", match_cnt, 255);
    do_stop();

    // asynchronous reset mid-run
    do_cfg(4'b1011, 4, 1'b1, 0, 1'b1);
    send(1'b1, 1'b1, 1'b0, "t6_out");
    send(1'b0, 1'b1, 1'b0, "t6_out");
    send(1'b1, 1'b1, 1'b0, "t6_out");
    signal = 1'b1; sig_valid = 1'b1;
    #2 rst = 1'b0;
    #1;
    chk("t6_rst_out", out, 0);
    chk("t6_rst_cnt", match_cnt, 0);
    chk("t6_rst_irq", irq, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_err", cfg_err, 0);
    sig_valid = 1'b0;
    tick();
    #2 rst = 1'b1;
    tick();
    do_cfg(4'b1011, 4, 1'b1, 0, 1'b1);
    s = 8'b00001011;
    for (int i = 4; i < 8; i++) send(s[7-i], 1'b1, e[7-i], "t6_out2");
    chk("t6_cnt", match_cnt, 1);
    do_stop();

    // randomized traffic, checked every cycle by the model
    for (int it = 0; it < 3000; it++) begin
      cfg_valid   = ($urandom % 8) == 0;
      cfg_pattern = PAT_W'($urandom);
      cfg_len     = (($urandom % 6) == 0) ? LEN_W'($urandom % 8) : LEN_W'(1 + $urandom % PAT_W);
      cfg_overlap = $urandom % 2;
      cfg_thresh  = CNT_W'($urandom % 6);
      start       = ($urandom % 6) == 0;
      stop        = ($urandom % 25) == 0;
      sig_valid   = ($urandom % 4) != 0;
      signal      = $urandom % 2;
      if (!rst) begin
        #2 rst = 1'b1;
      end else if (($urandom % 400) == 0) begin
        #2 rst = 1'b0;
      end
      tick();
    end
    cfg_valid = 1'b0; start = 1'b0; stop = 1'b0; sig_valid = 1'b0;
    #2 rst = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/seq_det_ctrl.md
Name: seq_det_ctrl

Overview:
Programmable controller for the serial sequence detector. It accepts a pattern configuration (pattern bits, length, overlapping or non-overlapping mode, match threshold) through a ready/valid handshake. It sequences the detector through idle, run and halt phases. While running it scans a qualified serial bit stream, pulses on each match, counts matches and raises a sticky interrupt when the threshold is reached.

Parameters:
PAT_W, 4, maximum pattern length in bits
CNT_W, 8, width of match counter and threshold
LEN_W, $clog2(PAT_W+1), width of cfg_len

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-low reset
cfg_valid  input  1  configuration write request
cfg_ready  output  1  high only in IDLE
cfg_pattern  input  PAT_W  pattern; bit [len-1] is the oldest/first bit, bit 0 is the newest
cfg_len  input  LEN_W  pattern length, legal range 1..PAT_W
cfg_overlap  input  1  1 = overlapping detection, 0 = non-overlapping
cfg_thresh  input  CNT_W  match count that halts the run; 0 = never halt
cfg_err  output  1  one-cycle pulse when an illegal cfg_len is rejected
start  input  1  begin a run (IDLE only)
stop  input  1  abort a run (RUN or HALT)
signal  input  1  serial data bit
sig_valid  input  1  qualifies signal
out  output  1  one-cycle match pulse
match_cnt  output  CNT_W  matches in the current run
irq  output  1  sticky threshold-reached flag
busy  output  1  high in RUN or HALT

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; out=0, match_cnt=0, irq=0, cfg_err=0.
  - Internal config clears to pattern=0, len=PAT_W, overlap=1, thresh=0.
  - History register and fill counter clear to 0.
  - Reset takes effect immediately, including mid-run.
- States: IDLE, RUN, HALT. cfg_ready=(state==IDLE). busy=(state!=IDLE).
- Configuration:
  - A write happens on a clk edge when cfg_valid && cfg_ready.
  - If cfg_len is 0 or greater than PAT_W, the write is rejected: config is unchanged and cfg_err pulses for one cycle.
  - cfg_valid outside IDLE is ignored, with no error.
- IDLE -> RUN on start.
  - On this transition, clear match_cnt, irq, history and fill.
  - If cfg_valid and start occur in the same cycle, the new config (when legal) applies to that run.
- RUN, on each edge with sig_valid=1:
  - hist_n = {hist[PAT_W-2:0], signal}; fill_n = min(fill+1, PAT_W).
  - Match when fill_n >= len and hist_n[len-1:0] == pattern[len-1:0].
- Match response:
  - out is registered: high for exactly the one cycle following the sampling edge (latency 1).
  - match_cnt increments at the same edge and saturates at 2^CNT_W-1.
  - Non-overlapping mode: on a match, fill is set to 0 so the next match needs len fresh bits.
  - Overlapping mode: fill is unchanged.
- sig_valid=0 in RUN: history, fill and counters hold; out=0.
- Threshold: if thresh != 0 and the incremented match_cnt == thresh, go to HALT and set irq at the same edge.
- HALT:
  - Input bits are ignored; out=0; match_cnt and irq hold.
  - start has no effect.
- stop in RUN or HALT -> IDLE at the next edge.
  - irq clears; match_cnt holds for readout until the next start.
  - The bit sampled on the stop edge is discarded, with no match.
  - stop beats start.
  - stop in IDLE has no effect.
- Unknown state encoding recovers to IDLE.

Test Plan:
- Reset, then config pattern=4'b1011, len=4, overlap=1, thresh=0, start; drive bits 1,1,0,1,1,0,1,1 with sig_valid=1 -> out pulses one cycle after bits 5 and 8; match_cnt=2; irq=0; busy=1.
- Same stream with overlap=0 -> single out pulse after bit 5; match_cnt=1.
- Overlap=1, thresh=2, stream 1,0,1,1,0,1,1,1 -> matches at bits 4 and 7; HALT entered and irq=1 at the bit-7 edge; bit 8 ignored; stop -> IDLE, irq=0, match_cnt=2, cfg_ready=1.
- cfg_len=0 in IDLE -> cfg_err one-cycle pulse, config unchanged; cfg_valid while busy=1 -> ignored; start and stop together in IDLE -> stays IDLE.
- Insert sig_valid=0 gaps inside a 1011 occurrence -> match still detected, with out one cycle after the final valid bit; len=2, pattern=2'b11 on stream 1,1,1 with overlap=1 -> match_cnt=2.
- Assert rst mid-run after 3 bits -> all outputs 0 asynchronously and state IDLE; after release, a new start plus a full 1011 -> match_cnt=1.
